// File: rtl/xyolo_vwrite_serializer.sv
// xyolo_vwrite_serializer
//   Buffers N_LANES result lanes in per-lane memories and drains them to the
//   external databus as a stride-addressed stream of words. The internal read
//   address walks a 2-D pattern: int_addr + it*shift + p*incr.
//
// Ports:
//   clk, rst (async, active-low)     clock and reset
//   run / done                       start pulse / idle flag
//   cfg_*                            transfer configuration, sampled on run in IDLE
//   lane_we, lane_waddr, lane_wdata  write port into all lane memories (lane 0 = MSB slice)
//   databus_*                        valid/ready write request stream
module xyolo_vwrite_serializer #(
  parameter int DATA_W     = 32,
  parameter int N_LANES    = 8,
  parameter int MEM_ADDR_W = 10,
  parameter int IO_ADDR_W  = 32,
  parameter int CNT_W      = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run,
  output logic                           done,
  input  logic [IO_ADDR_W-1:0]           cfg_ext_addr,
  input  logic [MEM_ADDR_W-1:0]          cfg_int_addr,
  input  logic [$clog2(N_LANES+1)-1:0]   cfg_lanes,
  input  logic [CNT_W-1:0]               cfg_iter,
  input  logic [CNT_W-1:0]               cfg_per,
  input  logic [MEM_ADDR_W-1:0]          cfg_incr,
  input  logic [MEM_ADDR_W-1:0]          cfg_shift,
  input  logic                           lane_we,
  input  logic [MEM_ADDR_W-1:0]          lane_waddr,
  input  logic [N_LANES*DATA_W-1:0]      lane_wdata,
  output logic                           databus_valid,
  output logic [IO_ADDR_W-1:0]           databus_addr,
  output logic [DATA_W-1:0]              databus_wdata,
  output logic [DATA_W/8-1:0]            databus_wstrb,
  input  logic                           databus_ready
);

  localparam int LANE_W = $clog2(N_LANES+1);
  localparam int STRB_W = DATA_W/8;
  localparam int DEPTH  = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t                    state_r;
  logic                      skip_r;
  logic [LANE_W-1:0]         lanes_r;
  logic [CNT_W-1:0]          iter_r;
  logic [CNT_W-1:0]          per_r;
  logic [MEM_ADDR_W-1:0]     incr_r;
  logic [MEM_ADDR_W-1:0]     shift_r;
  logic [CNT_W-1:0]          it_r;
  logic [CNT_W-1:0]          p_r;
  logic [LANE_W-1:0]         lane_r;
  logic [MEM_ADDR_W-1:0]     row_addr_r;
  logic [MEM_ADDR_W-1:0]     rd_addr_r;
  logic [N_LANES*DATA_W-1:0] mem_q_r;
  logic [N_LANES*DATA_W-1:0] hold_r;

  logic [DATA_W-1:0] mem [0:N_LANES-1][0:DEPTH-1];

  logic [LANE_W-1:0] lanes_sat_s;
  logic              cfg_zero_s;
  logic              last_lane_s;
  logic              last_p_s;
  logic              last_it_s;

  // Lane i of a packed lane vector; lane 0 occupies the most significant slice.
  function automatic logic [DATA_W-1:0] lane_word(input logic [N_LANES*DATA_W-1:0] flat,
                                                  input logic [LANE_W-1:0] idx);
    lane_word = flat[(N_LANES - 1 - int'(idx)) * DATA_W +: DATA_W];
  endfunction

  // Config decode and end-of-loop detection.
  always_comb begin
    lanes_sat_s = cfg_lanes;
    if (cfg_lanes > LANE_W'(N_LANES)) begin
      lanes_sat_s = LANE_W'(N_LANES);
    end else begin
      lanes_sat_s = cfg_lanes;
    end
    cfg_zero_s  = (cfg_lanes == '0) || (cfg_iter == '0) || (cfg_per == '0);
    last_lane_s = (lane_r == lanes_r - LANE_W'(1));
    last_p_s    = (p_r == per_r - CNT_W'(1));
    last_it_s   = (it_r == iter_r - CNT_W'(1));
  end

  // Lane memory write port: free-running, independent of the drain FSM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_we) begin
        mem[i][lane_waddr] <= lane_wdata[(N_LANES-1-i)*DATA_W +: DATA_W];
      end
    end
  end

  // Lane memory read port: one-cycle latency, read-first against a same-cycle write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LANES; i++) begin
      if (state_r == FETCH) begin
        mem_q_r[(N_LANES-1-i)*DATA_W +: DATA_W] <= mem[i][rd_addr_r];
      end
    end
  end

  // Drain FSM with registered databus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      skip_r        <= 1'b0;
      lanes_r       <= '0;
      iter_r        <= '0;
      per_r         <= '0;
      incr_r        <= '0;
      shift_r       <= '0;
      it_r          <= '0;
      p_r           <= '0;
      lane_r        <= '0;
      row_addr_r    <= '0;
      rd_addr_r     <= '0;
      hold_r        <= '0;
      done          <= 1'b1;
      databus_valid <= 1'b0;
      databus_addr  <= '0;
      databus_wdata <= '0;
      databus_wstrb <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (run) begin
            lanes_r      <= lanes_sat_s;
            iter_r       <= cfg_iter;
            per_r        <= cfg_per;
            incr_r       <= cfg_incr;
            shift_r      <= cfg_shift;
            it_r         <= '0;
            p_r          <= '0;
            lane_r       <= '0;
            row_addr_r   <= cfg_int_addr;
            rd_addr_r    <= cfg_int_addr;
            databus_addr <= cfg_ext_addr;
            done         <= 1'b0;
            // An empty transfer still passes through LATCH so done dips for one cycle.
            skip_r       <= cfg_zero_s;
            state_r      <= cfg_zero_s ? LATCH : FETCH;
          end else begin
            done <= 1'b1;
          end
        end
        FETCH: begin
          state_r <= LATCH;
        end
        LATCH: begin
          if (skip_r) begin
            skip_r  <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            hold_r        <= mem_q_r;
            lane_r        <= '0;
            databus_wdata <= lane_word(mem_q_r, LANE_W'(0));
            databus_wstrb <= '1;
            databus_valid <= 1'b1;
            state_r       <= SEND;
          end
        end
        SEND: begin
          if (databus_ready) begin
            databus_addr <= databus_addr + IO_ADDR_W'(STRB_W);
            if (last_lane_s) begin
              databus_valid <= 1'b0;
              databus_wstrb <= '0;
              lane_r        <= '0;
              if (last_p_s) begin
                p_r <= '0;
                if (last_it_s) begin
                  it_r    <= '0;
                  done    <= 1'b1;
                  state_r <= IDLE;
                end else begin
                  // New outer step restarts the inner walk from the shifted row base.
                  it_r       <= it_r + CNT_W'(1);
                  row_addr_r <= row_addr_r + shift_r;
                  rd_addr_r  <= row_addr_r + shift_r;
                  state_r    <= FETCH;
                end
              end else begin
                p_r       <= p_r + CNT_W'(1);
                rd_addr_r <= rd_addr_r + incr_r;
                state_r   <= FETCH;
              end
            end else begin
              lane_r        <= lane_r + LANE_W'(1);
              databus_wdata <= lane_word(hold_r, lane_r + LANE_W'(1));
            end
          end else begin
            // Stalled: every databus output holds its value.
            lane_r <= lane_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xyolo_vwrite_serializer.sv
// Directed table-driven bench for xyolo_vwrite_serializer (N_LANES=4).
// Lane memory word at (lane l, address a) is {14'b0, a, 8'hA0+l}.
module tb_xyolo_vwrite_serializer;

  localparam int DATA_W = 32;
  localparam int NL     = 4;
  localparam int MAW    = 10;
  localparam int IAW    = 32;
  localparam int CW     = 10;
  localparam int LW     = $clog2(NL+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              done;
  logic [IAW-1:0]    cfg_ext_addr;
  logic [MAW-1:0]    cfg_int_addr;
  logic [LW-1:0]     cfg_lanes;
  logic [CW-1:0]     cfg_iter;
  logic [CW-1:0]     cfg_per;
  logic [MAW-1:0]    cfg_incr;
  logic [MAW-1:0]    cfg_shift;
  logic              lane_we;
  logic [MAW-1:0]    lane_waddr;
  logic [NL*DATA_W-1:0] lane_wdata;
  logic              databus_valid;
  logic [IAW-1:0]    databus_addr;
  logic [DATA_W-1:0] databus_wdata;
  logic [DATA_W/8-1:0] databus_wstrb;
  logic              databus_ready;

  int checks = 0;
  int errors = 0;

  xyolo_vwrite_serializer #(
    .DATA_W(DATA_W), .N_LANES(NL), .MEM_ADDR_W(MAW), .IO_ADDR_W(IAW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .done(done),
    .cfg_ext_addr(cfg_ext_addr), .cfg_int_addr(cfg_int_addr), .cfg_lanes(cfg_lanes),
    .cfg_iter(cfg_iter), .cfg_per(cfg_per), .cfg_incr(cfg_incr), .cfg_shift(cfg_shift),
    .lane_we(lane_we), .lane_waddr(lane_waddr), .lane_wdata(lane_wdata),
    .databus_valid(databus_valid), .databus_addr(databus_addr),
    .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
    .databus_ready(databus_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LW-1:0]      lanes;
    logic [CW-1:0]      iter;
    logic [CW-1:0]      per;
    logic [MAW-1:0]     int_addr;
    logic [MAW-1:0]     incr;
    logic [MAW-1:0]     shift;
    logic [IAW-1:0]     ext;
    logic [31:0]        exp_lanes;
    logic [31:0]        exp_words;
    logic [0:5][MAW-1:0] pts;
  } vec_t;

  vec_t vecs [0:6];

  function automatic logic [31:0] pat(input int lane, input logic [MAW-1:0] a);
    pat = {14'd0, a, 8'hA0 + 8'(lane)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Runs one table vector; rnd selects random ready, extra pulses run while busy.
  task automatic run_vec(input int v, input bit rnd, input bit extra);
    vec_t t;
    int k;
    int last;
    int pt;
    int ln;
    bit fin;
    bit pv;
    bit pr;
    logic [31:0] pa;
    logic [31:0] pd;
    t = vecs[v];
    k = 0; last = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
    @(negedge clk);
    cfg_lanes = t.lanes; cfg_iter = t.iter; cfg_per = t.per;
    cfg_int_addr = t.int_addr; cfg_incr = t.incr; cfg_shift = t.shift;
    cfg_ext_addr = t.ext;
    databus_ready = 1'b0;
    run = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (extra && cyc == 5) begin
        run = 1'b1;
        cfg_ext_addr = 32'hDEAD_0000;
        cfg_lanes = 3'd4;
      end else begin
        run = 1'b0;
      end
      if (cyc == 1) chk("done_fall", {31'd0, done}, 32'd0);
      if (pv && !pr) begin
        chk("stall_valid", {31'd0, databus_valid}, 32'd1);
        chk("stall_addr", databus_addr, pa);
        chk("stall_wdata", databus_wdata, pd);
      end
      if (done) begin
        chk("done_valid_low", {31'd0, databus_valid}, 32'd0);
        if (t.exp_words == 32'd0) chk("empty_done_cycle", cyc, 32'd2);
        else chk("done_after_last", cyc, last + 1);
        fin = 1'b1;
        break;
      end
      databus_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (databus_valid && databus_ready) begin
        if (k >= int'(t.exp_words)) begin
          chk("extra_word", k, t.exp_words);
        end else begin
          pt = k / int'(t.exp_lanes);
          ln = k % int'(t.exp_lanes);
          chk("wdata", databus_wdata, pat(ln, t.pts[pt]));
          chk("addr", databus_addr, t.ext + 32'(4 * k));
          chk("wstrb", {28'd0, databus_wstrb}, 32'hF);
          if (!rnd) begin
            if (k == 0) chk("first_latency", cyc, 32'd3);
            else if (ln == 0) chk("point_bubble", cyc, last + 3);
            else chk("b2b", cyc, last + 1);
          end
        end
        last = cyc;
        k++;
      end
      pv = databus_valid; pr = databus_ready;
      pa = databus_addr; pd = databus_wdata;
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    chk("word_count", k, t.exp_words);
    databus_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{lanes: 3'd4, iter: 10'd1, per: 10'd1, int_addr: 10'd0, incr: 10'd0, shift: 10'd0,
                ext: 32'h0000_1000, exp_lanes: 32'd4, exp_words: 32'd4,
                pts: '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}};
    vecs[1] = '{lanes: 3'd2, iter: 10'd2, per: 10'd3, int_addr: 10'd5, incr: 10'd1, shift: 10'd10,
                ext: 32'h0000_2000, exp_lanes: 32'd2, exp_words: 32'd12,
                pts: '{10'd5, 10'd6, 10'd7, 10'd15, 10'd16, 10'd17}};
    vecs[2] = '{lanes: 3'd2, iter: 10'd1, per: 10'd2, int_addr: 10'd1023, incr: 10'd1, shift: 10'd0,
                ext: 32'hFFFF_FFF8, exp_lanes: 32'd2, exp_words: 32'd4,
                pts: '{10'd1023, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}};
    vecs[3] = '{lanes: 3'd7, iter: 10'd1, per: 10'd1, int_addr: 10'd3, incr: 10'd0, shift: 10'd0,
                ext: 32'h0000_3000, exp_lanes: 32'd4, exp_words: 32'd4,
                pts: '{10'd3, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}};
    vecs[4] = '{lanes: 3'd1, iter: 10'd3, per: 10'd1, int_addr: 10'd2, incr: 10'd0, shift: 10'd4,
                ext: 32'h0000_4000, exp_lanes: 32'd1, exp_words: 32'd3,
                pts: '{10'd2, 10'd6, 10'd10, 10'd0, 10'd0, 10'd0}};
    vecs[5] = '{lanes: 3'd3, iter: 10'd2, per: 10'd0, int_addr: 10'd0, incr: 10'd1, shift: 10'd1,
                ext: 32'h0000_5000, exp_lanes: 32'd3, exp_words: 32'd0,
                pts: '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}};
    vecs[6] = '{lanes: 3'd0, iter: 10'd1, per: 10'd1, int_addr: 10'd0, incr: 10'd0, shift: 10'd0,
                ext: 32'h0000_6000, exp_lanes: 32'd1, exp_words: 32'd0,
                pts: '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}};

    rst = 1'b0; run = 1'b0; databus_ready = 1'b0;
    cfg_ext_addr = '0; cfg_int_addr = '0; cfg_lanes = '0; cfg_iter = '0; cfg_per = '0;
    cfg_incr = '0; cfg_shift = '0; lane_we = 1'b0; lane_waddr = '0; lane_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd1);
    chk("rst_valid", {31'd0, databus_valid}, 32'd0);
    chk("rst_addr", databus_addr, 32'd0);
    chk("rst_wdata", databus_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, databus_wstrb}, 32'd0);

    for (int a = 0; a < 1024; a++) begin
      lane_we = 1'b1;
      lane_waddr = MAW'(a);
      lane_wdata = {pat(0, MAW'(a)), pat(1, MAW'(a)), pat(2, MAW'(a)), pat(3, MAW'(a))};
      @(negedge clk);
    end
    lane_we = 1'b0;

    for (int v = 0; v < 7; v++) run_vec(v, 1'b0, v == 1);
    run_vec(1, 1'b1, 1'b0);
    run_vec(3, 1'b1, 1'b0);

    // Reset asserted in the middle of SEND.
    @(negedge clk);
    cfg_lanes = 3'd2; cfg_iter = 10'd2; cfg_per = 10'd3; cfg_int_addr = 10'd5;
    cfg_incr = 10'd1; cfg_shift = 10'd10; cfg_ext_addr = 32'h0000_2000;
    run = 1'b1; databus_ready = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", {31'd0, databus_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, databus_valid}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd1);
    chk("async_rst_addr", databus_addr, 32'd0);
    chk("async_rst_wstrb", {28'd0, databus_wstrb}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    databus_ready = 1'b0;
    run_vec(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
